mux_n_to_one_registered: RTL

- Parameterised N-input, N_BITS-wide multiplexer with a registered output stage and valid/ready handshaking on every input channel and on the output.
- Successor to the combinational 2-to-1 mux used in the MEM-stage datapath.
- Adds runtime choice of two modes: explicit selector, or round-robin arbitration among valid inputs.
- Used where several producers, such as write-back sources or memory response ports, share one downstream consumer.

---
 rtl/mux_n_to_one_registered.sv | 114 +++++++++++
 1 files changed

// File: rtl/mux_n_to_one_registered.sv
// N-input, N_BITS-wide multiplexer with a registered output stage and
// valid/ready handshaking on every input channel and on the output.
// Channel choice is either an explicit selector or round-robin arbitration
// among valid inputs, switchable at runtime.
module mux_n_to_one_registered #(
  parameter int unsigned N_BITS   = 8,
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned SEL_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Round_Robin_Enable,
  input  logic [SEL_BITS-1:0]          Selector,
  input  logic [N_INPUTS*N_BITS-1:0]   Data_In,
  input  logic [N_INPUTS-1:0]          In_Valid,
  output logic [N_INPUTS-1:0]          In_Ready,
  output logic [N_BITS-1:0]            Mux_Output,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [SEL_BITS-1:0]          Out_Channel,
  output logic                         Sel_Error
);

  localparam int unsigned LAST_CH = N_INPUTS - 1;

  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] grant_idx;
  logic [SEL_BITS-1:0] next_ptr;
  logic                grant_valid;
  logic                slot_free;
  logic                transfer;
  logic                sel_out_of_range;
  logic [N_BITS-1:0]   grant_data;

  // Output register can take a new word when empty or draining this cycle
  assign slot_free        = !Out_Valid || Out_Ready;
  assign sel_out_of_range = 32'(Selector) >= N_INPUTS;
  assign transfer         = slot_free && grant_valid && !reset;

  // Pointer for the channel after the one being granted, wrapping at N_INPUTS
  assign next_ptr = (grant_idx == SEL_BITS'(LAST_CH)) ? '0 : grant_idx + SEL_BITS'(1);

  // Grant selection: selector match, or first valid channel scanning from rr_ptr
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (Round_Robin_Enable) begin
      // First pass: channels rr_ptr .. N_INPUTS-1
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        if (!grant_valid && In_Valid[i] && (SEL_BITS'(i) >= rr_ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_BITS'(i);
        end
      end
      // Second pass: wrapped channels 0 .. rr_ptr-1
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        if (!grant_valid && In_Valid[i] && (SEL_BITS'(i) < rr_ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_BITS'(i);
        end
      end
    end else begin
      // An out-of-range selector matches no channel, so it never grants
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        if (In_Valid[i] && (Selector == SEL_BITS'(i))) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_BITS'(i);
        end
      end
    end
  end

  // Data path mux for the granted channel
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (grant_idx == SEL_BITS'(i)) begin
        grant_data = Data_In[i*N_BITS +: N_BITS];
      end
    end
  end

  // Per-channel ready: only the granted channel, only when the slot is free
  always_comb begin
    In_Ready = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      In_Ready[i] = slot_free && grant_valid && (grant_idx == SEL_BITS'(i)) && !reset;
    end
  end

  // Output register, channel tag, selector error pulse and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      Mux_Output  <= '0;
      Out_Valid   <= 1'b0;
      Out_Channel <= '0;
      Sel_Error   <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      Sel_Error <= !Round_Robin_Enable && sel_out_of_range;
      if (transfer) begin
        Mux_Output  <= grant_data;
        Out_Channel <= grant_idx;
        Out_Valid   <= 1'b1;
        if (Round_Robin_Enable) begin
          rr_ptr <= next_ptr;
        end
      end else if (Out_Valid && Out_Ready) begin
        Out_Valid <= 1'b0;
      end
    end
  end

endmodule
